// File: rtl/encoder_pkg.sv
// Shared definitions for the sequential priority encoder: state encoding
// and the index-width helper used to size binary outputs.
package encoder_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   // Number of bits needed to hold an index in 0..w-1 (never less than 1).
   function automatic int idx_width(input int w);
      int bits;
      bits = $clog2(w);
      if (bits < 1) bits = 1;
      return bits;
   endfunction

endpackage

// File: rtl/priority_encoder.sv
// Combinational first-set-bit finder. Returns the lowest set index when
// MSB_FIRST=0, or the highest set index when MSB_FIRST=1. An all-zero
// request yields index 0; callers qualify that case themselves.
module priority_encoder
   import encoder_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int MSB_FIRST = 0,
   localparam int IDX_W    = idx_width(WIDTH)
) (
   input  logic [WIDTH-1:0] req_i,
   output logic [IDX_W-1:0] idx_o
);

   // Scan so that the winning bit is the last one assigned.
   always_comb begin
      idx_o = '0;
      if (MSB_FIRST == 0) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IDX_W'(i);
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (req_i[i]) idx_o = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/seq_priority_encoder.sv
// Sequential priority encoder: captures a multi-hot request vector and
// emits the index of each set bit, one per accepted beat, in priority
// order. All outputs come straight from registers; the next index is
// looked up from the next-state pending vector so it is ready one cycle
// after capture or after each accepted beat.
module seq_priority_encoder
   import encoder_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int MSB_FIRST = 0,
   localparam int IDX_W    = idx_width(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] encoder_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] binary_out,
   output logic             out_last
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [IDX_W-1:0] binary_q;
   logic [IDX_W-1:0] first_idx_d;
   logic             last_q, last_d;

   priority_encoder #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_prio (
      .req_i (pending_d),
      .idx_o (first_idx_d)
   );

   // Next-state: capture in IDLE, retire the presented bit on each accepted beat.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && enable && (encoder_in != '0)) begin
               pending_d = encoder_in;
               state_d   = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (out_ready) begin
               pending_d = pending_q & ~(ONE << binary_q);
               if (last_q) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Exactly one bit set: non-zero and clearing the lowest bit leaves zero.
      last_d = (pending_d != '0) && ((pending_d & (pending_d - ONE)) == '0);
   end

   // State and output registers; reset wins over any handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         binary_q  <= '0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         binary_q  <= (state_d == ST_EMIT) ? first_idx_d : '0;
         last_q    <= (state_d == ST_EMIT) ? last_d : 1'b0;
      end
   end

   assign in_ready   = (state_q == ST_IDLE);
   assign out_valid  = (state_q == ST_EMIT);
   assign binary_out = binary_q;
   assign out_last   = last_q;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Bench for seq_priority_encoder: two instances (LSB-first and MSB-first)
// share one stimulus stream. The reference model holds, per instance, the
// queue of indices still to be emitted for the captured vector.
module tb_seq_priority_encoder;

   localparam int W  = 16;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          reset, enable, in_valid, out_ready;
   logic [W-1:0]  encoder_in;
   logic          in_ready_l, out_valid_l, out_last_l;
   logic [IW-1:0] binary_out_l;
   logic          in_ready_m, out_valid_m, out_last_m;
   logic [IW-1:0] binary_out_m;

   int checks = 0;
   int errors = 0;

   int  q_lsb[$];
   int  q_msb[$];
   bit  zero_known;

   always #5 clk = ~clk;

   seq_priority_encoder #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .in_valid   (in_valid),
      .in_ready   (in_ready_l),
      .encoder_in (encoder_in),
      .out_valid  (out_valid_l),
      .out_ready  (out_ready),
      .binary_out (binary_out_l),
      .out_last   (out_last_l)
   );

   seq_priority_encoder #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .in_valid   (in_valid),
      .in_ready   (in_ready_m),
      .encoder_in (encoder_in),
      .out_valid  (out_valid_m),
      .out_ready  (out_ready),
      .binary_out (binary_out_m),
      .out_last   (out_last_m)
   );

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: check current outputs against the model, drive inputs,
   // advance the model, then move to the next falling edge.
   task automatic step(input bit rst, input bit en, input bit iv,
                       input logic [W-1:0] vec, input bit ordy);
      bit busy;
      busy = (q_lsb.size() != 0);
      check_val("lsb_valid", int'(out_valid_l), int'(busy));
      check_val("lsb_ready", int'(in_ready_l), int'(!busy));
      check_val("lsb_last",  int'(out_last_l), int'(busy && q_lsb.size() == 1));
      check_val("msb_valid", int'(out_valid_m), int'(busy));
      check_val("msb_ready", int'(in_ready_m), int'(!busy));
      check_val("msb_last",  int'(out_last_m), int'(busy && q_msb.size() == 1));
      if (busy) begin
         check_val("lsb_idx", int'(binary_out_l), q_lsb[0]);
         check_val("msb_idx", int'(binary_out_m), q_msb[0]);
      end else if (zero_known) begin
         check_val("lsb_idx_zero", int'(binary_out_l), 0);
         check_val("msb_idx_zero", int'(binary_out_m), 0);
      end

      reset      = rst;
      enable     = en;
      in_valid   = iv;
      encoder_in = vec;
      out_ready  = ordy;

      if (rst) begin
         q_lsb.delete();
         q_msb.delete();
         zero_known = 1'b1;
         $display("reset");
      end else if (busy) begin
         if (ordy) begin
            void'(q_lsb.pop_front());
            void'(q_msb.pop_front());
         end
      end else if (iv && en && vec != '0) begin
         for (int i = 0; i < W; i++)       if (vec[i]) q_lsb.push_back(i);
         for (int i = W - 1; i >= 0; i--)  if (vec[i]) q_msb.push_back(i);
         zero_known = 1'b0;
         $display("capture vec=%04h bits=%0d", vec, q_lsb.size());
      end

      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0; encoder_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      zero_known = 1'b1;
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

      // Enable low: requests ignored.
      repeat (3) step(1'b0, 1'b0, 1'b1, 16'h0001, 1'b1);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

      // Multi-bit vector, full-rate consumer.
      step(1'b0, 1'b1, 1'b1, 16'h8105, 1'b1);
      repeat (6) step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);

      // Back-pressure holds the presented index.
      step(1'b0, 1'b1, 1'b1, 16'h0006, 1'b0);
      repeat (4) step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      repeat (3) step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);

      // All-zero vector is dropped.
      repeat (2) step(1'b0, 1'b1, 1'b1, 16'h0000, 1'b1);
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);

      // Reset in the middle of an emission.
      step(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1);
      repeat (3) step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
      step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
      repeat (4) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

      // Randomized traffic, including enable toggling mid-emission.
      for (int n = 0; n < 2000; n++) begin
         logic [W-1:0] v;
         bit r, e, iv, o;
         case ($urandom_range(3))
            0:       v = '0;
            1:       v = W'($urandom) & W'($urandom) & W'($urandom);
            default: v = W'($urandom);
         endcase
         r  = ($urandom_range(99) == 0);
         e  = ($urandom_range(3) != 0);
         iv = ($urandom_range(1) == 0);
         o  = ($urandom_range(2) != 0);
         step(r, e, iv, v, o);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_priority_encoder.md
SEQ_PRIORITY_ENCODER -- requirements
Module: seq_priority_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the number of request bits in encoder_in (legal range 2..256).
REQ-002 SHALL have parameter MSB_FIRST, default 0, meaning emission order: 0 emits the lowest index first, 1 emits the highest index first.
REQ-003 SHALL derive localparam IDX_W = ceil(log2(WIDTH)); it is not user-overridable.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port enable  input  1  capture enable; gates acceptance of new vectors only.
REQ-007 SHALL have port in_valid  input  1  encoder_in carries a vector.
REQ-008 SHALL have port in_ready  output  1  block can accept a vector.
REQ-009 SHALL have port encoder_in  input  WIDTH  multi-hot request vector.
REQ-010 SHALL have port out_valid  output  1  binary_out holds a valid index.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the index.
REQ-012 SHALL have port binary_out  output  IDX_W  index of the current set bit.
REQ-013 SHALL have port out_last  output  1  current index is the final one of the captured vector.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (in_ready=1, out_valid=0) and EMIT (in_ready=0, out_valid=1).
REQ-015 SHALL, in IDLE, on in_valid=1 and enable=1 and encoder_in!=0, latch encoder_in into a WIDTH-bit pending register and go to EMIT.
REQ-016 SHALL, in IDLE, accept and silently drop a vector of all zeros (in_valid=1, enable=1) and remain in IDLE.
REQ-017 SHALL ignore in_valid while enable=0; no capture occurs and in_ready remains 1.
REQ-018 SHALL present the first index on the cycle after capture (latency 1 cycle from the accepting edge to out_valid=1).
REQ-019 SHALL drive binary_out with the index of the lowest set pending bit when MSB_FIRST=0, or the highest set pending bit when MSB_FIRST=1.
REQ-020 SHALL assert out_last when exactly one pending bit remains.
REQ-021 SHALL, on out_valid=1 and out_ready=1, clear the emitted bit; when out_last=1 it SHALL return to IDLE, otherwise stay in EMIT.
REQ-022 SHALL hold binary_out and out_last stable while out_valid=1 and out_ready=0.
REQ-023 SHALL sustain one index per cycle while out_ready=1; a vector with K set bits occupies exactly K EMIT cycles.
REQ-024 SHALL insert exactly one IDLE cycle between consecutive vectors; in_ready SHALL never be asserted in EMIT.
REQ-025 SHALL derive out_valid, binary_out, out_last and in_ready from registers only, with no combinational path from any input.
REQ-026 SHALL have enable changes during EMIT affect nothing; emission of the captured vector always completes.

Reset
REQ-027 SHALL, on reset=1 at a rising edge, enter IDLE, clear the pending register, and drive out_valid=0, out_last=0, binary_out=0, in_ready=1 from the next cycle.
REQ-028 SHALL give reset priority over every handshake; a reset mid-EMIT discards all remaining indices.

Structure
REQ-029 SHALL place the state encodings (IDLE=0, EMIT=1) and the index-width helper function in shared package encoder_pkg.
REQ-030 SHALL instantiate one combinational sub-module, priority_encoder (parameters WIDTH, MSB_FIRST), mapping the pending vector to the first set index.

Verification (WIDTH=16)
REQ-031 SHALL test: enable=0, in_valid=1, encoder_in=16'h0001 for 3 cycles -> in_ready=1 throughout, out_valid never 1.
REQ-032 SHALL test: MSB_FIRST=0, enable=1, encoder_in=16'h8105, out_ready=1 -> binary_out 0,2,8,15 on consecutive cycles, out_last only with 15, then in_ready=1.
REQ-033 SHALL test: MSB_FIRST=1, encoder_in=16'h8105 -> binary_out 15,8,2,0, out_last only with 0.
REQ-034 SHALL test: encoder_in=16'h0006 with out_ready=0 for 4 cycles -> binary_out=1 held with out_valid=1, then 2 with out_last=1 after out_ready=1.
REQ-035 SHALL test: in_valid=1, encoder_in=16'h0000 -> dropped, out_valid stays 0, in_ready stays 1.
REQ-036 SHALL test: encoder_in=16'hFFFF, reset=1 after 3 beats -> next cycle out_valid=0, in_ready=1, binary_out=0, and no further indices.
